// File: rtl/tri_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tri_bus_arbiter
//  Purpose  : Round-robin arbiter driving one shared tristate bus, with
//             turnaround gaps, hold limit, bus parking and contention flag.
//  Revision : 1.0  initial release
// ============================================================================
module tri_bus_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NAGENTS    = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16,
  parameter int PULL_MODE  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NAGENTS-1:0]         req,
  input  logic [NAGENTS*WIDTH-1:0]   wdata,
  inout  wire  [WIDTH-1:0]           bus,
  output logic [NAGENTS-1:0]         gnt,
  output logic [$clog2(NAGENTS)-1:0] owner,
  output logic [WIDTH-1:0]           rdata,
  output logic                       bus_idle,
  output logic                       contention,
  input  logic                       clr_cont
);

  localparam int c_OWN_W  = $clog2(NAGENTS);
  localparam int c_HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int c_TURN_W = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
  localparam bit c_HOLD_EN = (MAX_HOLD > 0);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(MAX_HOLD);
  localparam logic [c_TURN_W-1:0] c_TURN_LAST = c_TURN_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TURN  = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                r_state;
  logic [NAGENTS-1:0]    r_gnt;
  logic [c_OWN_W-1:0]    r_owner;
  logic [c_OWN_W-1:0]    r_next;
  logic [c_HOLD_W-1:0]   r_hold_cnt;
  logic [c_TURN_W-1:0]   r_turn_cnt;
  logic [WIDTH-1:0]      r_rdata;
  logic                  r_bus_idle;
  logic                  r_contention;

  logic [c_OWN_W-1:0]    w_pick;
  logic [c_OWN_W-1:0]    w_turn_pick;
  logic                  w_release;
  logic                  w_oe;
  logic [WIDTH-1:0]      w_drive;

  // The current owner sits last in the rotation, so a forced release hands
  // the bus to any other requester before the owner can win it back.
  function automatic logic [c_OWN_W-1:0] f_rr_pick(input logic [NAGENTS-1:0] r,
                                                   input logic [c_OWN_W-1:0] base);
    logic [c_OWN_W-1:0] pick;
    logic               found;
    int                 idx;
    pick  = base;
    found = 1'b0;
    for (int i = 1; i <= NAGENTS; i++) begin
      idx = (int'(base) + i) % NAGENTS;
      if (!found && r[c_OWN_W'(idx)]) begin
        pick  = c_OWN_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NAGENTS-1:0] f_onehot(input logic [c_OWN_W-1:0] idx);
    return {{(NAGENTS-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign w_pick      = f_rr_pick(req, r_owner);
  assign w_turn_pick = req[r_next] ? r_next : w_pick;
  assign w_release   = ~req[r_owner] | (c_HOLD_EN && (r_hold_cnt == c_HOLD_LAST));
  assign w_oe        = |r_gnt;
  assign w_drive     = wdata[int'(r_owner)*WIDTH +: WIDTH];
  assign bus         = w_oe ? w_drive : {WIDTH{1'bz}};

  generate
    if (PULL_MODE == 1) begin : g_pulldown
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pulldown u_pd (bus[i]);
      end
    end else if (PULL_MODE == 2) begin : g_pullup
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pullup u_pu (bus[i]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_owner      <= '0;
      r_next       <= '0;
      r_hold_cnt   <= '0;
      r_turn_cnt   <= '0;
      r_rdata      <= '0;
      r_bus_idle   <= 1'b1;
      r_contention <= 1'b0;
    end else begin
      r_rdata <= bus;
      // A fresh mismatch outranks a clear in the same cycle.
      if (w_oe && (bus !== w_drive)) begin
        r_contention <= 1'b1;
      end else if (clr_cont) begin
        r_contention <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (|req) begin
            if (TURNAROUND == 0) begin
              r_owner    <= w_pick;
              r_gnt      <= f_onehot(w_pick);
              r_bus_idle <= 1'b0;
              r_hold_cnt <= '0;
              r_state    <= S_DRIVE;
            end else begin
              r_next     <= w_pick;
              r_turn_cnt <= '0;
              r_state    <= S_TURN;
            end
          end
        end
        S_TURN: begin
          if (r_turn_cnt == c_TURN_LAST) begin
            if (|req) begin
              r_owner    <= w_turn_pick;
              r_gnt      <= f_onehot(w_turn_pick);
              r_bus_idle <= 1'b0;
              r_hold_cnt <= '0;
              r_state    <= S_DRIVE;
            end else begin
              r_state    <= S_IDLE;
            end
          end else begin
            r_turn_cnt <= r_turn_cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (w_release) begin
            if ((|req) && (TURNAROUND == 0)) begin
              r_owner    <= w_pick;
              r_gnt      <= f_onehot(w_pick);
              r_hold_cnt <= '0;
            end else begin
              r_gnt      <= '0;
              r_bus_idle <= 1'b1;
              if (|req) begin
                r_next     <= w_pick;
                r_turn_cnt <= '0;
                r_state    <= S_TURN;
              end else begin
                r_state    <= S_IDLE;
              end
            end
          end else if (r_hold_cnt != c_HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_gnt      <= '0;
          r_bus_idle <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign owner      = r_owner;
  assign rdata      = r_rdata;
  assign bus_idle   = r_bus_idle;
  assign contention = r_contention;

endmodule
`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tri_bus_arbiter
//  Purpose  : Directed vector bench for tri_bus_arbiter across three configs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tri_bus_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_a, req_b, req_c;
  logic [N*W-1:0] wdata_a, wdata_b, wdata_c;
  logic           clr_a, clr_off, ext_en;
  wire  [W-1:0]   bus_a, bus_b, bus_c;
  logic [N-1:0]   gnt_a, gnt_b, gnt_c;
  logic [1:0]     owner_a, owner_b, owner_c;
  logic [W-1:0]   rdata_a, rdata_b, rdata_c;
  logic           idle_a, idle_b, idle_c;
  logic           cont_a, cont_b, cont_c;

  assign bus_a = ext_en ? 8'hC3 : 8'hzz;

  // A: pullup parking, unlimited hold
  tri_bus_arbiter #(.WIDTH(W), .NAGENTS(N), .TURNAROUND(1), .MAX_HOLD(0), .PULL_MODE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .wdata(wdata_a), .bus(bus_a), .gnt(gnt_a),
    .owner(owner_a), .rdata(rdata_a), .bus_idle(idle_a), .contention(cont_a), .clr_cont(clr_a));

  // B: pulldown parking, hold limit of 4
  tri_bus_arbiter #(.WIDTH(W), .NAGENTS(N), .TURNAROUND(1), .MAX_HOLD(4), .PULL_MODE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .wdata(wdata_b), .bus(bus_b), .gnt(gnt_b),
    .owner(owner_b), .rdata(rdata_b), .bus_idle(idle_b), .contention(cont_b), .clr_cont(clr_off));

  // C: back-to-back handover, plain tri
  tri_bus_arbiter #(.WIDTH(W), .NAGENTS(N), .TURNAROUND(0), .MAX_HOLD(0), .PULL_MODE(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .wdata(wdata_c), .bus(bus_c), .gnt(gnt_c),
    .owner(owner_c), .rdata(rdata_c), .bus_idle(idle_c), .contention(cont_c), .clr_cont(clr_off));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input int d, input logic [3:0] r, input logic [3:0] g,
                              input logic [1:0] o);
    vec_t v;
    v.dut = d; v.req = r; v.gnt = g; v.owner = o;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_bus(input int d, input logic [3:0] g);
    logic [N*W-1:0] wd;
    logic [7:0]     val;
    wd  = (d == 0) ? wdata_a : (d == 1) ? wdata_b : wdata_c;
    val = (d == 0) ? 8'hFF : 8'h00;
    for (int j = 0; j < N; j++) begin
      if (g[j]) val = wd[j*W +: W];
    end
    return val;
  endfunction

  initial begin
    vec_t       v;
    logic [3:0] s_gnt;
    logic [1:0] s_owner;
    logic [7:0] s_bus, s_rdata, e_bus;
    logic       s_idle, known;
    logic [7:0] prev_bus [3];
    logic       prev_ok  [3];

    req_a = '0; req_b = '0; req_c = '0;
    clr_a = 1'b0; clr_off = 1'b0; ext_en = 1'b0;
    wdata_a = {8'h44, 8'hA5, 8'h22, 8'h11};
    wdata_b = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    wdata_c = {8'h8F, 8'h7E, 8'h6D, 8'h5C};

    // RR on A: every agent holds three cycles, one Z cycle between owners
    add(0, 4'b1111, 4'b0000, 2'd0); add(0, 4'b1111, 4'b0010, 2'd1);
    add(0, 4'b1111, 4'b0010, 2'd1); add(0, 4'b1111, 4'b0010, 2'd1);
    add(0, 4'b1101, 4'b0000, 2'd1); add(0, 4'b1101, 4'b0100, 2'd2);
    add(0, 4'b1101, 4'b0100, 2'd2); add(0, 4'b1101, 4'b0100, 2'd2);
    add(0, 4'b1001, 4'b0000, 2'd2); add(0, 4'b1001, 4'b1000, 2'd3);
    add(0, 4'b1001, 4'b1000, 2'd3); add(0, 4'b1001, 4'b1000, 2'd3);
    add(0, 4'b0001, 4'b0000, 2'd3); add(0, 4'b0001, 4'b0001, 2'd0);
    add(0, 4'b0001, 4'b0001, 2'd0); add(0, 4'b0001, 4'b0001, 2'd0);
    add(0, 4'b0000, 4'b0000, 2'd0); add(0, 4'b0000, 4'b0000, 2'd0);
    // Hold limit on B: park owner at 1 first so agent0 wins the 0011 race
    add(1, 4'b0010, 4'b0000, 2'd0); add(1, 4'b0010, 4'b0010, 2'd1);
    add(1, 4'b0000, 4'b0000, 2'd1); add(1, 4'b0011, 4'b0000, 2'd1);
    add(1, 4'b0011, 4'b0001, 2'd0); add(1, 4'b0011, 4'b0001, 2'd0);
    add(1, 4'b0011, 4'b0001, 2'd0); add(1, 4'b0011, 4'b0001, 2'd0);
    add(1, 4'b0011, 4'b0000, 2'd0); add(1, 4'b0011, 4'b0010, 2'd1);
    add(1, 4'b0011, 4'b0010, 2'd1); add(1, 4'b0011, 4'b0010, 2'd1);
    add(1, 4'b0011, 4'b0010, 2'd1); add(1, 4'b0011, 4'b0000, 2'd1);
    add(1, 4'b0011, 4'b0001, 2'd0); add(1, 4'b0000, 4'b0000, 2'd0);
    add(1, 4'b0000, 4'b0000, 2'd0);
    // Zero turnaround on C: handover on the same edge
    add(2, 4'b0001, 4'b0001, 2'd0); add(2, 4'b0101, 4'b0001, 2'd0);
    add(2, 4'b0100, 4'b0100, 2'd2); add(2, 4'b0100, 4'b0100, 2'd2);
    add(2, 4'b0101, 4'b0100, 2'd2); add(2, 4'b0001, 4'b0001, 2'd0);
    add(2, 4'b0000, 4'b0000, 2'd0); add(2, 4'b0000, 4'b0000, 2'd0);

    // Reset state
    repeat (2) tick();
    chk("reset gnt", 32'(gnt_a), 32'h0);
    chk("reset owner", 32'(owner_a), 32'h0);
    chk("reset rdata", 32'(rdata_a), 32'h0);
    chk("reset bus_idle", 32'(idle_a), 32'h1);
    chk("reset contention", 32'(cont_a), 32'h0);

    // Async reset while agent 2 drives
    rst_n = 1'b1;
    repeat (2) tick();
    req_a = 4'b0100;
    tick();
    chk("latency turn gnt", 32'(gnt_a), 32'h0);
    tick();
    chk("latency gnt", 32'(gnt_a), 32'h4);
    chk("agent2 bus", 32'(bus_a), 32'hA5);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset bus", 32'(bus_a), 32'hFF);
    chk("async reset gnt", 32'(gnt_a), 32'h0);
    tick();
    chk("async reset rdata", 32'(rdata_a), 32'h0);
    req_a = '0;
    rst_n = 1'b1;
    repeat (2) tick();
    chk("pullup idle rdata", 32'(rdata_a), 32'hFF);
    chk("pulldown idle rdata", 32'(rdata_b), 32'h00);

    wdata_a = {8'h44, 8'h33, 8'h22, 8'h11};
    prev_bus[0] = 8'hFF; prev_bus[1] = 8'h00; prev_bus[2] = 8'h00;
    prev_ok[0]  = 1'b1;  prev_ok[1]  = 1'b1;  prev_ok[2]  = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      req_a = (v.dut == 0) ? v.req : 4'b0000;
      req_b = (v.dut == 1) ? v.req : 4'b0000;
      req_c = (v.dut == 2) ? v.req : 4'b0000;
      tick();
      case (v.dut)
        0:       begin s_gnt = gnt_a; s_owner = owner_a; s_bus = bus_a; s_rdata = rdata_a; s_idle = idle_a; end
        1:       begin s_gnt = gnt_b; s_owner = owner_b; s_bus = bus_b; s_rdata = rdata_b; s_idle = idle_b; end
        default: begin s_gnt = gnt_c; s_owner = owner_c; s_bus = bus_c; s_rdata = rdata_c; s_idle = idle_c; end
      endcase
      e_bus = exp_bus(v.dut, v.gnt);
      known = (v.gnt != 4'b0000) || (v.dut != 2);
      chk($sformatf("vec%0d gnt", i), 32'(s_gnt), 32'(v.gnt));
      chk($sformatf("vec%0d owner", i), 32'(s_owner), 32'(v.owner));
      chk($sformatf("vec%0d bus_idle", i), 32'(s_idle), 32'(v.gnt == 4'b0000));
      if (known) chk($sformatf("vec%0d bus", i), 32'(s_bus), 32'(e_bus));
      if (prev_ok[v.dut]) chk($sformatf("vec%0d rdata", i), 32'(s_rdata), 32'(prev_bus[v.dut]));
      prev_bus[v.dut] = e_bus;
      prev_ok[v.dut]  = known;
    end
    req_a = '0; req_b = '0; req_c = '0;

    // Contention: external driver fights agent 1
    wdata_a = {8'h44, 8'h33, 8'h3C, 8'h11};
    req_a = 4'b0010;
    repeat (2) tick();
    chk("cont gnt", 32'(gnt_a), 32'h2);
    chk("cont bus", 32'(bus_a), 32'h3C);
    chk("cont clean", 32'(cont_a), 32'h0);
    ext_en = 1'b1;
    tick();
    chk("cont set", 32'(cont_a), 32'h1);
    ext_en = 1'b0;
    req_a  = '0;
    tick();
    chk("cont release gnt", 32'(gnt_a), 32'h0);
    chk("cont sticky1", 32'(cont_a), 32'h1);
    tick();
    chk("cont sticky2", 32'(cont_a), 32'h1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("cont cleared", 32'(cont_a), 32'h0);
    req_a = 4'b0010;
    repeat (2) tick();
    chk("cont regrant", 32'(gnt_a), 32'h2);
    ext_en = 1'b1;
    clr_a  = 1'b1;
    tick();
    chk("cont set beats clear", 32'(cont_a), 32'h1);
    ext_en = 1'b0;
    req_a  = '0;
    tick();
    tick();
    clr_a = 1'b0;
    chk("cont final clear", 32'(cont_a), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
